// File: rtl/sdh_pkg.sv
// Shared types and constants for the sensitive-data handling pipeline.
package sdh_pkg;

    localparam int unsigned SDH_WIDTH = 128;

    typedef logic [SDH_WIDTH-1:0] sdh_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCRUB = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/processed_data_drain_fifo_if.sv
// Producer/consumer handshake, scrub control and occupancy for the drain FIFO.
interface processed_data_drain_fifo_if
    import sdh_pkg::*;
#(
    parameter int unsigned WIDTH = SDH_WIDTH,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             scrub_req;
    logic             scrub_busy;
    logic             scrub_done;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, out_ready, scrub_req,
        input  in_ready, out_valid, out_data, scrub_busy, scrub_done, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, scrub_req,
        output in_ready, out_valid, out_data, scrub_busy, scrub_done, count
    );

endinterface

// File: rtl/processed_data_drain_fifo.sv
// Zeroizing drain FIFO for processed sensitive words; every freed slot is wiped.
// Optional full-buffer scrub engine enabled by DRAIN_FIFO_SCRUB_EN.
module processed_data_drain_fifo
    import sdh_pkg::*;
#(
    parameter int unsigned WIDTH = SDH_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input logic                         clk,
    input logic                         rst,
    processed_data_drain_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    drain_state_e     state;
    logic [PTR_W-1:0] scrub_idx;
    logic             scrub_wipe;
    logic             scrub_finish;

    logic push;
    logic pop;

`ifdef DRAIN_FIFO_SCRUB_EN
    drain_state_e     state_nxt;
    logic [PTR_W-1:0] scrub_idx_nxt;
    logic             scrub_last;

    assign scrub_last = (scrub_idx == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scrub_idx <= '0;
        end else begin
            state     <= state_nxt;
            scrub_idx <= scrub_idx_nxt;
        end
    end

    // Requests arriving while SCRUB/DONE are dropped, never queued
    always_comb begin
        state_nxt     = state;
        scrub_idx_nxt = scrub_idx;
        case (state)
            IDLE: begin
                if (bus.scrub_req) begin
                    state_nxt     = SCRUB;
                    scrub_idx_nxt = '0;
                end
            end
            SCRUB: begin
                scrub_idx_nxt = scrub_idx + PTR_W'(1);
                if (scrub_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign scrub_wipe     = (state == SCRUB);
    assign scrub_finish   = scrub_wipe && scrub_last;
    assign bus.scrub_busy = (state == SCRUB);
    assign bus.scrub_done = (state == DONE);
`else
    logic unused_scrub_req;

    assign unused_scrub_req = bus.scrub_req;
    assign state            = IDLE;
    assign scrub_idx        = '0;
    assign scrub_wipe       = 1'b0;
    assign scrub_finish     = 1'b0;
    assign bus.scrub_busy   = 1'b0;
    assign bus.scrub_done   = 1'b0;
`endif

    // Handshake qualifiers come only from registered state
    assign bus.in_ready  = (count != CNT_W'(DEPTH)) && (state == IDLE);
    assign bus.out_valid = (count != '0) && (state == IDLE);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.count     = count;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Storage: push writes, pop and scrub write zero; wr_ptr != rd_ptr whenever both fire
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (scrub_wipe) begin
            mem[scrub_idx] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.in_data;
            end
            if (pop) begin
                mem[rd_ptr] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || scrub_finish) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_processed_data_drain_fifo.sv
// Directed self-checking bench for processed_data_drain_fifo (scrub cases under DRAIN_FIFO_SCRUB_EN).
module tb_processed_data_drain_fifo;
    import sdh_pkg::*;

    localparam int unsigned WIDTH = SDH_WIDTH;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    processed_data_drain_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    processed_data_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem_zero(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check(tag, dut.mem[i], 128'd0);
        end
    endtask

    initial begin
        logic [127:0] pat;
        int busy_cycles;
        int done_pulses;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.scrub_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_count",     128'(bus.count),      128'd0);
        check("rst_out_valid", 128'(bus.out_valid),  128'd0);
        check("rst_out_data",  bus.out_data,         128'd0);
        check("rst_in_ready",  128'(bus.in_ready),   128'd1);
        check("rst_busy",      128'(bus.scrub_busy), 128'd0);
        check("rst_done",      128'(bus.scrub_done), 128'd0);
        check_mem_zero("rst_mem");

        // Fill 1..4 with consumer stalled
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 128'(i);
            tick();
            if (i == 1) begin
                check("lat_out_valid", 128'(bus.out_valid), 128'd1);
                check("lat_out_data",  bus.out_data,        128'd1);
            end
        end
        check("full_count",    128'(bus.count),    128'd4);
        check("full_in_ready", 128'(bus.in_ready), 128'd0);
        bus.in_data = 128'd5;
        tick();
        check("full_refuse_count", 128'(bus.count), 128'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("pop_order", bus.out_data, 128'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain_count",     128'(bus.count),     128'd0);
        check("drain_out_valid", 128'(bus.out_valid), 128'd0);
        check("drain_out_data",  bus.out_data,        128'd0);
        check_mem_zero("drain_mem");

        // Zeroize on pop; both pointers are at entry 0 here
        pat          = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        bus.in_valid = 1'b1;
        bus.in_data  = pat;
        tick();
        bus.in_valid = 1'b0;
        check("zp_mem_before", dut.mem[0], pat);
        check("zp_out_data",   bus.out_data, pat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("zp_mem_after",  dut.mem[0], 128'd0);
        check("zp_out_after",  bus.out_data, 128'd0);
        check("zp_count",      128'(bus.count), 128'd0);

        // Full with in_valid and out_ready both high
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 128'(16 + i);
            tick();
        end
        bus.in_data   = 128'd20;
        bus.out_ready = 1'b1;
        tick();
        check("fullpp_count", 128'(bus.count), 128'd3);
        check("fullpp_head",  bus.out_data,    128'd17);
        tick();
        check("fullpp_count2", 128'(bus.count), 128'd3);
        check("fullpp_head2",  bus.out_data,    128'd18);
        bus.in_valid = 1'b0;
        for (int i = 18; i <= 20; i++) begin
            check("fullpp_order", bus.out_data, 128'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("fullpp_empty", 128'(bus.count), 128'd0);

        // Steady one-in/one-out at count 2 over 40 cycles
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 128'(32 + i);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.in_data = 128'(34 + k);
            check("steady_head", bus.out_data, 128'(32 + k));
            tick();
            check("steady_count", 128'(bus.count), 128'd2);
        end
        bus.in_valid = 1'b0;
        check("steady_tail0", bus.out_data, 128'd72);
        tick();
        check("steady_tail1", bus.out_data, 128'd73);
        tick();
        bus.out_ready = 1'b0;
        check("steady_empty", 128'(bus.count), 128'd0);

`ifdef DRAIN_FIFO_SCRUB_EN
        // Scrub: 3 stored plus one pushed in the request cycle, all wiped
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 128'(80 + i);
            tick();
        end
        bus.in_data   = 128'd83;
        bus.scrub_req = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.scrub_req = 1'b0;
        check("scrub_in_ready",  128'(bus.in_ready),  128'd0);
        check("scrub_out_valid", 128'(bus.out_valid), 128'd0);
        check("scrub_out_data",  bus.out_data,        128'd0);
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.scrub_busy) busy_cycles++;
            if (bus.scrub_done) done_pulses++;
            bus.scrub_req = (c == 1);
            tick();
        end
        bus.scrub_req = 1'b0;
        check("scrub_busy_cycles", 128'(busy_cycles), 128'd4);
        check("scrub_done_pulses", 128'(done_pulses), 128'd1);
        check("scrub_count",       128'(bus.count),   128'd0);
        check("scrub_out_valid2",  128'(bus.out_valid), 128'd0);
        check("scrub_in_ready2",   128'(bus.in_ready),  128'd1);
        check_mem_zero("scrub_mem");

        // Reset during the second scrub cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 128'd90;
        tick();
        bus.in_valid  = 1'b0;
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
        tick();
        check("abort_busy_pre", 128'(bus.scrub_busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",     128'(bus.scrub_busy), 128'd0);
        check("abort_in_ready", 128'(bus.in_ready),   128'd1);
        check("abort_count",    128'(bus.count),      128'd0);
        check_mem_zero("abort_mem");
        done_pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.scrub_done) done_pulses++;
            tick();
        end
        check("abort_no_done", 128'(done_pulses), 128'd0);
`else
        // Scrub disabled: request has no effect on data or flow
        bus.in_valid = 1'b1;
        bus.in_data  = 128'd90;
        tick();
        bus.in_valid  = 1'b0;
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
        check("noscrub_busy",  128'(bus.scrub_busy), 128'd0);
        check("noscrub_count", 128'(bus.count),      128'd1);
        check("noscrub_data",  bus.out_data,         128'd90);
        tick();
        check("noscrub_done",  128'(bus.scrub_done), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_count",    128'(bus.count),    128'd0);
        check("rst2_in_ready", 128'(bus.in_ready), 128'd1);
        check_mem_zero("rst2_mem");
`endif

        // Post-reset push/pop
        bus.in_valid = 1'b1;
        bus.in_data  = 128'hAA;
        tick();
        bus.in_valid = 1'b0;
        check("aa_count", 128'(bus.count), 128'd1);
        check("aa_data",  bus.out_data,    128'hAA);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("aa_empty",    128'(bus.count), 128'd0);
        check("aa_mem_zero", dut.mem[0],      128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processed_data_drain_fifo.md
# processed_data_drain_fifo

Downstream stage of the sensitive-data processing pipeline: accepts 128-bit processed words and buffers them in a small FIFO for a valid/ready consumer. Every storage slot is zeroized when it is reset, popped or scrubbed. Stale sensitive data never stays in a freed entry and is never visible on `out_data`. An optional scrub engine wipes the whole buffer on command, for key/context changes.

## Interface
- `WIDTH`, 128, data word width in bits
- `DEPTH`, 4, number of entries; power of two, ≥2
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream word valid
- `in_data`  in  WIDTH  processed word from upstream
- `in_ready`  out  1  FIFO can accept a word
- `out_valid`  out  1  head word valid
- `out_data`  out  WIDTH  head word; forced to all-zero when `out_valid`=0
- `out_ready`  in  1  consumer accepts head word
- `scrub_req`  in  1  request full-buffer wipe (single-cycle pulse or level)
- `scrub_busy`  out  1  scrub in progress
- `scrub_done`  out  1  one-cycle pulse, scrub finished
- `count`  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push when `in_valid && in_ready`: write `in_data` at `wr_ptr`, then `wr_ptr`+1 with natural wrap, `count`+1.
- Pop when `out_valid && out_ready`: write zero into the entry at `rd_ptr`, then `rd_ptr`+1 with wrap, `count`-1.
- `in_ready = (count < DEPTH) && state==IDLE`. No push when full, even with a same-cycle pop.
- `out_valid = (count != 0) && state==IDLE`.
- Push and pop in the same cycle: both happen, `count` is unchanged.
- The push always targets a different entry from the zeroized one unless `count`==0. In that case `out_valid`=0 and no pop occurs.
- On `rst`, all storage entries, pointers, `count` and FSM state clear to zero. All outputs are 0 except `in_ready`, which is 1 in the cycle after reset.
- Scrub FSM states: IDLE, SCRUB, DONE.
  - IDLE to SCRUB on `scrub_req`=1. Handshakes in that same cycle complete normally; a word pushed then is wiped.
  - In SCRUB, zero the entry at `scrub_idx` each cycle, with `scrub_idx` running from 0 to DEPTH-1. `in_ready`=0 and `out_valid`=0 throughout.
  - SCRUB to DONE after the entry at DEPTH-1 is zeroed. Pointers and `count` clear on this transition.
  - DONE: `scrub_done`=1 for one cycle, then IDLE.
  - `scrub_req` in SCRUB or DONE is ignored and not queued.
- `rst` mid-scrub aborts to IDLE; reset itself zeroes all storage.

## Timing
- Latency from push at edge N into an empty FIFO to `out_valid`=1: visible after edge N, i.e. 1 cycle.
- `out_data` is a registered-storage read muxed by `rd_ptr` and gated by `out_valid`. It has no combinational path from `in_data`.
- `in_ready` and `out_valid` depend only on registered state. There is no combinational path from any input.
- Scrub with `scrub_req` sampled at edge N:
  - `scrub_busy`=1 after edges N … N+DEPTH-1, i.e. DEPTH cycles.
  - `scrub_done`=1 for one cycle after edge N+DEPTH.
  - `in_ready` returns after edge N+DEPTH+1.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `DRAIN_FIFO_SCRUB_EN` defined: scrub FSM, `scrub_idx` counter and the `scrub_busy`/`scrub_done` logic are compiled in, behaving as above.
- Not defined:
  - `scrub_req` is ignored.
  - `scrub_busy` and `scrub_done` are tied to 0.
  - State is permanently IDLE.
  - Zeroize-on-pop and zeroize-on-reset remain unconditional.

## Structure
- Shared package `sdh_pkg`:
  - `SDH_WIDTH`=128 constant.
  - `sdh_word_t` typedef (logic [127:0]).
  - `drain_state_e` enum {IDLE, SCRUB, DONE}.
- Single module. No sub-module; storage, pointers and FSM are small enough to sit flat.

## Test plan
- Reset then idle:
  - `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1, `scrub_busy`=0.
  - Backdoor read shows all entries zero.
- Push 0x…01, 0x…02, 0x…03, 0x…04 with `out_ready`=0:
  - `count`=4 and `in_ready`=0.
  - A fifth push of 0x…05 is refused.
  - Pops return 01, 02, 03, 04 in order.
- Zeroize on pop: push 0xDEAD…BEEF, then pop it.
  - The backdoor entry at the old `rd_ptr` reads 0.
  - `out_data`=0 after the pop.
- Full FIFO with `in_valid`=`out_ready`=1: pops proceed and the push is refused while `count`=DEPTH. Steady one-in/one-out at `count`=2 keeps `count`=2 across 10 wraps of the pointers.
- Scrub (`DRAIN_FIFO_SCRUB_EN`):
  - Fill 3 entries, then pulse `scrub_req`.
  - `scrub_busy` is high for 4 cycles and `scrub_done` pulses once.
  - Afterwards all entries are 0, `count`=0 and `out_valid`=0.
  - A second `scrub_req` during busy is ignored.
- Assert `rst` during the 2nd scrub cycle:
  - Next cycle is IDLE with all storage 0.
  - `scrub_done` never pulses.
  - A push of 0x…AA is then accepted and returned correctly.
